regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-port GPR file with a write-pending scoreboard. It replaces the single-write, two-read regfile in the decode stage.
//  - NUM_RP parametrised read ports, each with same-cycle write bypass.
//  - Two write ports: wp0 = ALU writeback, wp1 = LSU writeback.
//  - Per-register busy bits: set at issue, cleared at writeback. Decode uses rbusy_o to stall.
//  - Read data is held when a port is not enabled; the hold is registered, never a combinational loop.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width
//  NUM_REGS  32  number of registers; index 0 is hardwired zero; NUM_REGS <= 2**ADDR_W
//  NUM_RP    2   number of read ports (1..4)
//  BYPASS    1   1 = write-port data forwarded to same-cycle reads; 0 = array data only
// PORTS
//  clk           in   1              clock, rising edge
//  rst_n         in   1              asynchronous active-low reset
//  raddr_i       in   NUM_RP*ADDR_W  read addresses; port k = [k*ADDR_W +: ADDR_W]
//  re_i          in   NUM_RP         read enables
//  rdata_o       out  NUM_RP*DATA_W  read data; port k = [k*DATA_W +: DATA_W]
//  rbusy_o       out  NUM_RP         source register has a pending, unresolved write
//  we0_i         in   1              write enable, port 0 (ALU)
//  waddr0_i      in   ADDR_W         write address, port 0
//  wdata0_i      in   DATA_W         write data, port 0
//  we1_i         in   1              write enable, port 1 (LSU)
//  waddr1_i      in   ADDR_W         write address, port 1
//  wdata1_i      in   DATA_W         write data, port 1
//  alloc_i       in   1              issue marks a destination register as pending
//  alloc_addr_i  in   ADDR_W         destination register to mark busy
//  busy_o        out  NUM_REGS       full scoreboard vector, for debug and flush logic
// BEHAVIOUR
//  Reset (async, rst_n=0): clears every GPR, every busy bit and every read-hold register to 0.
//   - Outputs read 0 while rst_n is low. Reset mid-operation discards pending busy bits.
//  Register 0: writes and allocs to address 0 are ignored. Reads of address 0 return 0.
//   - busy[0] is always 0 and rbusy for address 0 is always 0.
//  Array write (posedge clk):
//   - we0 writes wdata0 to waddr0; we1 writes wdata1 to waddr1.
//   - Both ports to the same address in the same cycle: port 1 wins.
//   - Addresses >= NUM_REGS are ignored.
//  Read, port k, combinational when re_i[k]=1:
//   - raddr==0 gives 0.
//   - Else, if BYPASS: match on we1/waddr1 gives wdata1; else match on we0/waddr0 gives wdata0.
//   - Else the array value. An address >= NUM_REGS reads 0.
//   - The same value is captured into hold_k at posedge.
//  Read with re_i[k]=0: rdata_o[k] = hold_k, the last value read while enabled. No latency.
//  Scoreboard (posedge clk), for each register r != 0:
//   - Set if alloc_i and alloc_addr_i==r.
//   - Else cleared if a write port targets r.
//   - Same-cycle alloc and write to r: busy stays 1, because the new producer supersedes the old write.
//  rbusy_o[k] = re_i[k] & busy[raddr_k] & ~(same-cycle write to raddr_k).
//   - The write match term applies only when BYPASS=1; with BYPASS=0 it is busy only.
//   - This is combinational, with zero-cycle visibility of a clearing write.
//  Alloc to an already busy register: busy remains 1. There is no counting; one write clears it.
//  Write to a register that is not busy: legal. The data is written and busy stays 0.
// TESTING
//  1. Reset: rst_n=0 mid-traffic -> all rdata_o=0, busy_o=0. After release, read x5 -> 0.
//  2. Dual write conflict: we0 x7=0x11 and we1 x7=0x22 in the same cycle -> next cycle read x7 = 0x22.
//  3. Bypass: we0 x3=0xDEAD with a same-cycle read of x3 -> rdata=0xDEAD.
//     - With BYPASS=0 -> rdata is the old array value.
//  4. Hold: read x4=0x55, then re=0 while x4 is written to 0x66 -> rdata stays 0x55.
//     - After re=1 -> 0x66.
//  5. Scoreboard:
//     - alloc x9 -> busy_o[9]=1 and rbusy=1 on a read of x9.
//     - we1 x9 -> rbusy=0 in the same cycle; busy_o[9]=0 the next cycle.
//     - alloc and write x9 in the same cycle -> busy_o[9] stays 1.
//  6. x0: we0 x0=0xFFFF and alloc x0 -> read x0 = 0, busy_o[0]=0. Repeat with NUM_RP=4 on all ports.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port GPR file with two write ports, same-cycle write forwarding,
// registered read-data hold and a per-register write-pending scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RP   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RP*ADDR_W-1:0]   raddr_i,
    input  logic [NUM_RP-1:0]          re_i,
    output logic [NUM_RP*DATA_W-1:0]   rdata_o,
    output logic [NUM_RP-1:0]          rbusy_o,
    input  logic                       we0_i,
    input  logic [ADDR_W-1:0]          waddr0_i,
    input  logic [DATA_W-1:0]          wdata0_i,
    input  logic                       we1_i,
    input  logic [ADDR_W-1:0]          waddr1_i,
    input  logic [DATA_W-1:0]          wdata1_i,
    input  logic                       alloc_i,
    input  logic [ADDR_W-1:0]          alloc_addr_i,
    output logic [NUM_REGS-1:0]        busy_o
);

    // One wider than an address so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] wsel0;
    logic [NUM_REGS-1:0] wsel1;
    logic [NUM_REGS-1:0] asel;

    // Per-register decode; entry 0 is never selected, which keeps x0 at zero
    // and its busy bit clear without any special casing downstream.
    always_comb begin
        wsel0 = '0;
        wsel1 = '0;
        asel  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            wsel0[r] = we0_i   && (waddr0_i     == ADDR_W'(r));
            wsel1[r] = we1_i   && (waddr1_i     == ADDR_W'(r));
            asel[r]  = alloc_i && (alloc_addr_i == ADDR_W'(r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wsel1[r]) begin
                    mem[r] <= wdata1_i;
                end else if (wsel0[r]) begin
                    mem[r] <= wdata0_i;
                end
            end
        end
    end

    // A same-cycle alloc wins over a clearing write: the new producer supersedes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (asel[r]) begin
                    busy_q[r] <= 1'b1;
                end else if (wsel0[r] || wsel1[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_o = busy_q;

    for (genvar k = 0; k < NUM_RP; k++) begin : g_rp
        logic [ADDR_W-1:0] addr;
        logic              valid;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] hold;

        assign addr  = raddr_i[k*ADDR_W +: ADDR_W];
        assign valid = ({1'b0, addr} < REG_LIMIT) && (addr != '0);
        assign hit1  = (BYPASS != 0) && we1_i && (waddr1_i == addr);
        assign hit0  = (BYPASS != 0) && we0_i && (waddr0_i == addr);

        always_comb begin
            val = '0;
            if (valid) begin
                if (hit1) begin
                    val = wdata1_i;
                end else if (hit0) begin
                    val = wdata0_i;
                end else begin
                    val = mem[addr];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold <= '0;
            end else if (re_i[k]) begin
                hold <= val;
            end
        end

        // A forwarded write resolves the hazard in the same cycle it is seen.
        assign rdata_o[k*DATA_W +: DATA_W] = !rst_n ? '0 : (re_i[k] ? val : hold);
        assign rbusy_o[k] = rst_n && re_i[k] && valid && busy_q[addr] && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 4-port forwarding instance and a 2-port
// non-forwarding instance share clock, reset, write and alloc stimulus.
module tb_regfile_mp;

    logic         clk;
    logic         rst_n;
    logic [19:0]  raddr;
    logic [3:0]   re;
    logic [127:0] rdata;
    logic [3:0]   rbusy;
    logic [31:0]  busy;
    logic [9:0]   raddr_nb;
    logic [1:0]   re_nb;
    logic [63:0]  rdata_nb;
    logic [1:0]   rbusy_nb;
    logic [31:0]  busy_nb;
    logic         we0;
    logic [4:0]   waddr0;
    logic [31:0]  wdata0;
    logic         we1;
    logic [4:0]   waddr1;
    logic [31:0]  wdata1;
    logic         alloc;
    logic [4:0]   alloc_addr;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RP(4), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr_i(raddr), .re_i(re), .rdata_o(rdata), .rbusy_o(rbusy),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .alloc_i(alloc), .alloc_addr_i(alloc_addr), .busy_o(busy)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RP(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .raddr_i(raddr_nb), .re_i(re_nb), .rdata_o(rdata_nb), .rbusy_o(rbusy_nb),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .alloc_i(alloc), .alloc_addr_i(alloc_addr), .busy_o(busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        re = '0; re_nb = '0;
        we0 = 1'b0; we1 = 1'b0; alloc = 1'b0;
    endtask

    task automatic rd_set(input int k, input logic [4:0] a);
        raddr[k*5 +: 5] = a;
        re[k] = 1'b1;
    endtask

    task automatic rd_set_nb(input int k, input logic [4:0] a);
        raddr_nb[k*5 +: 5] = a;
        re_nb[k] = 1'b1;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        we0 = 1'b1; waddr0 = a; wdata0 = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        we1 = 1'b1; waddr1 = a; wdata1 = d;
    endtask

    task automatic do_alloc(input logic [4:0] a);
        alloc = 1'b1; alloc_addr = a;
    endtask

    function automatic logic [31:0] rd(input int k);
        return rdata[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_nb(input int k);
        return rdata_nb[k*32 +: 32];
    endfunction

    task automatic test_reset();
        idle(); settle();
        checks++;
        if (rd(0) !== 32'h0) begin errors++; $display("FAIL reset_hold: got %h expected %h", rd(0), 32'h0); end
        checks++;
        if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, 32'h0); end
        wr0(5'd5, 32'h0000_00AB); do_alloc(5'd6);
        tick(); idle();
        rd_set(0, 5'd5); settle();
        checks++;
        if (rd(0) !== 32'h0000_00AB) begin errors++; $display("FAIL pre_reset_read: got %h expected %h", rd(0), 32'h0000_00AB); end
        checks++;
        if (busy !== 32'h0000_0040) begin errors++; $display("FAIL pre_reset_busy: got %h expected %h", busy, 32'h0000_0040); end
        // reset asserted mid-traffic with a forwarding write in flight
        wr1(5'd5, 32'h0000_00CD); rd_set_nb(0, 5'd5); do_alloc(5'd8);
        rst_n = 1'b0; settle();
        checks++;
        if (rdata !== 128'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++;
        if (rdata_nb !== 64'h0) begin errors++; $display("FAIL reset_rdata_nb: got %h expected 0", rdata_nb); end
        checks++;
        if (busy !== 32'h0 || busy_nb !== 32'h0) begin errors++; $display("FAIL reset_busy_async: got %h/%h expected 0", busy, busy_nb); end
        tick();
        rst_n = 1'b1; idle(); tick();
        rd_set(0, 5'd5); rd_set_nb(0, 5'd5); settle();
        checks++;
        if (rd(0) !== 32'h0 || rd_nb(0) !== 32'h0) begin errors++; $display("FAIL post_reset_x5: got %h/%h expected 0", rd(0), rd_nb(0)); end
        checks++;
        if (busy !== 32'h0) begin errors++; $display("FAIL post_reset_busy: got %h expected 0", busy); end
        tick(); idle();
    endtask

    task automatic test_dual_write();
        wr0(5'd7, 32'h11); wr1(5'd7, 32'h22);
        tick(); idle();
        rd_set(0, 5'd7); rd_set_nb(0, 5'd7); settle();
        checks++;
        if (rd(0) !== 32'h22) begin errors++; $display("FAIL dual_write: got %h expected %h", rd(0), 32'h22); end
        checks++;
        if (rd_nb(0) !== 32'h22) begin errors++; $display("FAIL dual_write_nb: got %h expected %h", rd_nb(0), 32'h22); end
        tick(); idle();
    endtask

    task automatic test_bypass();
        wr0(5'd3, 32'h1234);
        tick(); idle();
        wr0(5'd3, 32'hDEAD); rd_set(1, 5'd3); rd_set_nb(0, 5'd3); settle();
        checks++;
        if (rd(1) !== 32'hDEAD) begin errors++; $display("FAIL bypass_wp0: got %h expected %h", rd(1), 32'hDEAD); end
        checks++;
        if (rd_nb(0) !== 32'h1234) begin errors++; $display("FAIL nobypass_wp0: got %h expected %h", rd_nb(0), 32'h1234); end
        tick(); idle();
        wr0(5'd3, 32'hAAAA); wr1(5'd3, 32'hBBBB); rd_set(1, 5'd3); rd_set_nb(0, 5'd3); settle();
        checks++;
        if (rd(1) !== 32'hBBBB) begin errors++; $display("FAIL bypass_wp1_priority: got %h expected %h", rd(1), 32'hBBBB); end
        checks++;
        if (rd_nb(0) !== 32'hDEAD) begin errors++; $display("FAIL nobypass_array: got %h expected %h", rd_nb(0), 32'hDEAD); end
        tick(); idle();
        rd_set(1, 5'd3); settle();
        checks++;
        if (rd(1) !== 32'hBBBB) begin errors++; $display("FAIL bypass_committed: got %h expected %h", rd(1), 32'hBBBB); end
        tick(); idle();
    endtask

    task automatic test_hold();
        wr0(5'd4, 32'h55);
        tick(); idle();
        rd_set(2, 5'd4); settle();
        checks++;
        if (rd(2) !== 32'h55) begin errors++; $display("FAIL hold_first_read: got %h expected %h", rd(2), 32'h55); end
        tick(); idle();
        wr0(5'd4, 32'h66); raddr[2*5 +: 5] = 5'd7; settle();
        checks++;
        if (rd(2) !== 32'h55) begin errors++; $display("FAIL hold_during_write: got %h expected %h", rd(2), 32'h55); end
        tick(); idle(); settle();
        checks++;
        if (rd(2) !== 32'h55) begin errors++; $display("FAIL hold_after_write: got %h expected %h", rd(2), 32'h55); end
        rd_set(2, 5'd4); settle();
        checks++;
        if (rd(2) !== 32'h66) begin errors++; $display("FAIL hold_reenable: got %h expected %h", rd(2), 32'h66); end
        tick(); idle();
    endtask

    task automatic test_scoreboard();
        do_alloc(5'd9);
        tick(); idle();
        rd_set(0, 5'd9); rd_set_nb(0, 5'd9); settle();
        checks++;
        if (busy !== 32'h0000_0200) begin errors++; $display("FAIL sb_alloc_busy: got %h expected %h", busy, 32'h0000_0200); end
        checks++;
        if (rbusy[0] !== 1'b1 || rbusy_nb[0] !== 1'b1) begin errors++; $display("FAIL sb_rbusy_set: got %b/%b expected 1/1", rbusy[0], rbusy_nb[0]); end
        checks++;
        if (rbusy[1] !== 1'b0) begin errors++; $display("FAIL sb_rbusy_disabled: got %b expected 0", rbusy[1]); end
        wr1(5'd9, 32'h99); settle();
        checks++;
        if (rbusy[0] !== 1'b0 || rd(0) !== 32'h99) begin errors++; $display("FAIL sb_clear_bypass: got rbusy=%b data=%h expected 0/%h", rbusy[0], rd(0), 32'h99); end
        checks++;
        if (rbusy_nb[0] !== 1'b1) begin errors++; $display("FAIL sb_clear_nobypass: got %b expected 1", rbusy_nb[0]); end
        tick(); idle(); settle();
        checks++;
        if (busy !== 32'h0) begin errors++; $display("FAIL sb_cleared: got %h expected 0", busy); end
        do_alloc(5'd9); wr0(5'd9, 32'h77);
        tick(); idle(); settle();
        checks++;
        if (busy !== 32'h0000_0200) begin errors++; $display("FAIL sb_alloc_and_write: got %h expected %h", busy, 32'h0000_0200); end
        do_alloc(5'd10);
        tick(); idle();
        do_alloc(5'd10);
        tick(); idle();
        wr0(5'd10, 32'hA0); wr1(5'd9, 32'h90);
        tick(); idle(); settle();
        checks++;
        if (busy !== 32'h0) begin errors++; $display("FAIL sb_single_write_clears: got %h expected 0", busy); end
    endtask

    task automatic test_x0_multiport();
        wr0(5'd0, 32'hFFFF); wr1(5'd0, 32'h1111); do_alloc(5'd0);
        for (int k = 0; k < 4; k++) rd_set(k, 5'd0);
        settle();
        checks++;
        if (rdata !== 128'h0 || rbusy !== 4'h0) begin errors++; $display("FAIL x0_same_cycle: got %h rbusy=%b expected 0", rdata, rbusy); end
        tick(); idle();
        for (int k = 0; k < 4; k++) rd_set(k, 5'd0);
        settle();
        checks++;
        if (rdata !== 128'h0) begin errors++; $display("FAIL x0_read_all_ports: got %h expected 0", rdata); end
        checks++;
        if (busy[0] !== 1'b0 || rbusy !== 4'h0) begin errors++; $display("FAIL x0_busy: got busy0=%b rbusy=%b expected 0/0", busy[0], rbusy); end
        tick(); idle();
        wr0(5'd1, 32'h101); wr1(5'd2, 32'h202);
        tick(); idle();
        wr0(5'd11, 32'h111); wr1(5'd12, 32'h222);
        tick(); idle();
        rd_set(0, 5'd1); rd_set(1, 5'd2); rd_set(2, 5'd11); rd_set(3, 5'd12); settle();
        checks++;
        if (rdata !== {32'h222, 32'h111, 32'h202, 32'h101}) begin errors++; $display("FAIL multiport_read: got %h expected %h", rdata, {32'h222, 32'h111, 32'h202, 32'h101}); end
        tick(); idle();
    endtask

    initial begin
        rst_n = 1'b0;
        raddr = '0; raddr_nb = '0;
        waddr0 = '0; wdata0 = '0; waddr1 = '0; wdata1 = '0; alloc_addr = '0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_reset();
        test_dual_write();
        test_bypass();
        test_hold();
        test_scoreboard();
        test_x0_multiport();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
